// File: rtl/click_pkg.sv
// Shared types and defaults for the per-button single/double click classifier.
package click_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } click_state_t;

  // 300 ms at 125 MHz
  localparam int DEFAULT_WINDOW_CYCLES = 37_500_000;

endpackage

// File: rtl/click_detector.sv
// One button channel: waits out a window after a first press and reports
// either a single click (timeout) or a double click (second press in window).
import click_pkg::*;

module click_detector #(
  parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_press,
  output logic o_single,
  output logic o_double,
  output logic o_pending
);

  localparam int CNT_W = $clog2(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] TC = CNT_W'(WINDOW_CYCLES - 1);

  click_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_single;
  logic             r_double;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_single <= 1'b0;
      r_double <= 1'b0;
    end else begin
      r_single <= 1'b0;
      r_double <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_press) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          // a press on the terminal-count edge still wins over the timeout
          if (i_press) begin
            r_double <= 1'b1;
            r_state  <= IDLE;
          end else if (r_cnt == TC) begin
            r_single <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_single  = r_single;
  assign o_double  = r_double;
  assign o_pending = (r_state == WAIT);

endmodule

// File: rtl/click_classifier.sv
// Bank of independent click detectors, one per debounced button channel.
import click_pkg::*;

module click_classifier #(
  parameter int WIDTH         = 1,
  parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] single_click,
  output logic [WIDTH-1:0] double_click,
  output logic [WIDTH-1:0] pending
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    click_detector #(
      .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_det (
      .clk      (clk),
      .rst      (rst),
      .i_press  (press_pulse[g]),
      .o_single (single_click[g]),
      .o_double (double_click[g]),
      .o_pending(pending[g])
    );
  end

endmodule

// File: tb/tb_click_classifier.sv
// Randomized + directed bench for click_classifier against a timestamp-based model.
module tb_click_classifier;

  localparam int W  = 2;
  localparam int WC = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] press_pulse = '0;
  logic [W-1:0] single_click, double_click, pending;

  click_classifier #(.WIDTH(W), .WINDOW_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .press_pulse(press_pulse),
    .single_click(single_click), .double_click(double_click), .pending(pending)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // model: a channel is "armed" from the edge its first press is sampled
  int           cyc = 0;
  bit           armed [W];
  int           start [W];
  logic [W-1:0] m_s = '0, m_d = '0, m_p = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < W; c++) armed[c] = 0;
      m_s = '0; m_d = '0; m_p = '0;
    end else begin
      cyc++;
      for (int c = 0; c < W; c++) begin
        m_s[c] = 1'b0;
        m_d[c] = 1'b0;
        if (armed[c]) begin
          if (press_pulse[c]) begin
            m_d[c] = 1'b1; armed[c] = 0;
          end else if (cyc - start[c] == WC) begin
            m_s[c] = 1'b1; armed[c] = 0;
          end
        end else if (press_pulse[c]) begin
          armed[c] = 1; start[c] = cyc;
        end
        m_p[c] = armed[c];
      end
    end
  end

  // observation log, in spec cycle numbering (edge e -> cycle e+1)
  bit           chk_en = 0;
  int           last_s [W], last_d [W], n_s [W], n_d [W], n_p [W];
  logic [W-1:0] prev_s = '0, prev_d = '0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("single_click", single_click, m_s);
      check("double_click", double_click, m_d);
      check("pending", pending, m_p);
      n_cmp++;
      assert ((single_click & double_click) == '0 && (single_click & prev_s) == '0 &&
              (double_click & prev_d) == '0)
      else begin n_err++; $display("FAIL pulse_invariant: s=%b d=%b ps=%b pd=%b", single_click, double_click, prev_s, prev_d); end
      n_cmp++;
      assert (dut.g_ch[0].u_det.r_cnt <= 4'(WC-1) && dut.g_ch[1].u_det.r_cnt <= 4'(WC-1))
      else begin n_err++; $display("FAIL counter_bound: c0=%0d c1=%0d", dut.g_ch[0].u_det.r_cnt, dut.g_ch[1].u_det.r_cnt); end
      for (int c = 0; c < W; c++) begin
        if (single_click[c]) begin last_s[c] = cyc + 1; n_s[c]++; end
        if (double_click[c]) begin last_d[c] = cyc + 1; n_d[c]++; end
        if (pending[c]) n_p[c]++;
      end
      prev_s = single_click;
      prev_d = double_click;
    end
  end

  int t_drv;
  task automatic drive(input logic [W-1:0] m);
    @(negedge clk);
    press_pulse = m;
    t_drv = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0);
  endtask

  int t0, t1, s0, d0, p0, s1, d1;
  task automatic snap;
    s0 = n_s[0]; d0 = n_d[0]; p0 = n_p[0]; s1 = n_s[1]; d1 = n_d[1];
  endtask

  initial begin
    for (int c = 0; c < W; c++) begin
      last_s[c] = -1; last_d[c] = -1; n_s[c] = 0; n_d[c] = 0; n_p[c] = 0;
    end
    // reset and idle; outputs must clear before any clock edge
    rst = 1'b1;
    #1;
    check("reset_async_outputs", {single_click, double_click, pending}, 0);
    chk_en = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(30);
    check("idle_no_events", n_s[0] + n_s[1] + n_d[0] + n_d[1] + n_p[0] + n_p[1], 0);

    // single click on channel 0
    snap;
    drive(2'b01); t0 = t_drv;
    idle(20);
    check("single_cycle", last_s[0], t0 + WC + 1);
    check("single_pending_len", n_p[0] - p0, WC);
    check("single_no_double", n_d[0] - d0, 0);
    check("single_ch1_quiet", (n_s[1] - s1) + (n_d[1] - d1), 0);

    // double click on channel 1
    snap;
    drive(2'b10);
    idle(3);
    drive(2'b10); t1 = t_drv;
    idle(20);
    check("double_cycle", last_d[1], t1 + 1);
    check("double_no_single", n_s[1] - s1, 0);

    // second press exactly on the terminal-count edge
    snap;
    drive(2'b01); t0 = t_drv;
    idle(WC - 1);
    drive(2'b01);
    idle(20);
    check("edge_double_cycle", last_d[0], t0 + WC + 1);
    check("edge_no_single", n_s[0] - s0, 0);

    // one edge later: timeout fires, and the press opens a fresh window
    snap;
    drive(2'b01); t0 = t_drv;
    idle(WC);
    drive(2'b01);
    idle(20);
    check("late_single_count", n_s[0] - s0, 2);
    check("late_single_last", last_s[0], t0 + 2 * WC + 2);
    check("late_no_double", n_d[0] - d0, 0);

    // async reset mid-window discards the press
    snap;
    drive(2'b01);
    idle(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midreset_pending_drop", pending, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(25);
    check("midreset_no_events", (n_s[0] - s0) + (n_d[0] - d0), 0);

    // channels interleaved
    snap;
    drive(2'b01); t0 = t_drv;
    drive(2'b10); t1 = t_drv;
    drive(2'b01);
    idle(20);
    check("indep_double0", last_d[0], t0 + 3);
    check("indep_single1", last_s[1], t1 + WC + 1);
    check("indep_counts", (n_s[0] - s0) * 10 + (n_d[1] - d1), 0);

    // random presses, including back-to-back pulses
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] m;
      for (int c = 0; c < W; c++) m[c] = ($urandom_range(0, 6) == 0);
      drive(m);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk) rst = 1'b0;
      end
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
